a1a3_clock_phase_monitor: RTL and testbench
===========================================

// Module: a1a3_clock_phase_monitor
// PURPOSE
//  Receiving end of the A1A3 four-phase clock drivers: samples the W/X/Y/Z phase lines,
//  checks they cycle W->X->Y->Z->W with no overlap, and derives bit-time and
//  word-time counters for downstream timing logic. Raises a sticky fault on overlap,
//  out-of-order phase or stalled clock. Sits beside the clock drivers on the A1 page.
// PARAMETERS
//  BIT_TIMES    14    bit times per word; bit_time counts 0..BIT_TIMES-1
//  LOCK_CYCLES  4     consecutive clean W->X->Y->Z rotations required to assert locked
//  STALL_MAX    64    max clk cycles with no phase edge before stall fault
// PORTS
//  clk        in   1   simulation clock, rising edge, faster than any phase pulse
//  rst        in   1   asynchronous, active-high reset
//  w          in   1   W phase line from clock drivers (asynchronous to clk)
//  x          in   1   X phase line
//  y          in   1   Y phase line
//  z          in   1   Z phase line
//  fault_clr  in   1   synchronous pulse: clears fault, returns FSM to HUNT
//  phase      out  2   last active phase seen: 0=W 1=X 2=Y 3=Z
//  phase_stb  out  1   1-clk pulse on each accepted phase rising edge
//  bit_time   out  4   bit-time counter, advances on each accepted W edge while locked
//  word_stb   out  1   1-clk pulse when bit_time wraps BIT_TIMES-1 -> 0
//  locked     out  1   high in LOCKED state only
//  fault      out  1   sticky fault flag
//  fault_code out  2   1=overlap 2=order 3=stall; 0 when fault low
// BEHAVIOUR
//  Reset: all outputs 0, FSM=HUNT, synchronisers cleared, counters 0.
//  Input path: each of w/x/y/z through a 2-flop synchroniser, then a 3rd flop for edge detect.
//   Rising edge detected on synchronised line -> event valid at cycle +3 after input rises.
//  Overlap: more than one synchronised line high in same clk -> overlap fault (code 1);
//   takes priority over order/stall in the same cycle.
//  Expected next phase = (phase+1) mod 4. Edge on any other line -> order fault (code 2),
//   except in HUNT. Simultaneous edges on two lines count as overlap.
//  Stall counter: reset on any accepted edge, increments otherwise; reaching STALL_MAX in
//   SYNC or LOCKED -> stall fault (code 3). Not checked in HUNT or FAULT.
//  FSM:
//   HUNT   : wait for first W edge; on it phase=0, phase_stb=1, rotation count=0 -> SYNC.
//            X/Y/Z edges ignored (no stb).
//   SYNC   : accept in-order edges (phase_stb pulses, phase updates); each W edge completing
//            a full rotation increments rotation count; count==LOCK_CYCLES -> LOCKED,
//            bit_time=0 on that same W edge. Any fault -> FAULT.
//   LOCKED : locked=1. Each accepted W edge: bit_time+1; at BIT_TIMES-1 wrap to 0 and pulse
//            word_stb in same cycle as phase_stb. Any fault -> FAULT.
//   FAULT  : fault=1, fault_code held, locked=0, bit_time frozen, phase_stb/word_stb held 0,
//            further faults do not overwrite code. fault_clr -> HUNT, fault=0, code=0,
//            bit_time=0. fault_clr in other states: no effect.
//  Fault entry registered: fault/locked change in the cycle after the offending event.
//  rst mid-operation: immediate return to reset values regardless of state.
// TESTING
//  1 Clean rotation, each phase high 8 clk, gap 2 clk: locked rises on 5th W edge
//    (1 hunt + 4 rotations); bit_time 0..13, word_stb once per 14 W edges, fault stays 0.
//  2 While locked, raise X and Y together -> fault=1, code=1 next cycle, locked=0,
//    bit_time frozen; pulse fault_clr -> HUNT, fault=0, bit_time=0.
//  3 While in SYNC, drive W then Y (skip X) -> fault=1, code=2; later overlap does not
//    change code.
//  4 While locked, hold all lines low for STALL_MAX clk -> fault code=3 exactly on count 64.
//  5 Start stream at Z phase -> no phase_stb until first W; lock timing as scenario 1.
//  6 Assert rst mid-word (bit_time=7, locked) -> all outputs 0 asynchronously; after release,
//    relock per scenario 1.

Source files
------------

// File: rtl/a1a3_clock_phase_monitor.sv
// A1A3 four-phase clock monitor: synchronises W/X/Y/Z, checks W->X->Y->Z order,
// derives bit-time/word-time timing and flags overlap, order and stall faults.
module a1a3_clock_phase_monitor #(
    parameter int unsigned BIT_TIMES   = 14,
    parameter int unsigned LOCK_CYCLES = 4,
    parameter int unsigned STALL_MAX   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    input  logic       fault_clr,
    output logic [1:0] phase,
    output logic       phase_stb,
    output logic [3:0] bit_time,
    output logic       word_stb,
    output logic       locked,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
    localparam int unsigned ROT_W   = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_OVERLAP = 2'd1;
    localparam logic [1:0] CODE_ORDER   = 2'd2;
    localparam logic [1:0] CODE_STALL   = 2'd3;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED, FAULT} state_t;

    state_t             state, state_nxt;
    logic [3:0]         sync1, sync2, sync3;
    logic [STALL_W-1:0] stall_cnt, stall_nxt, stall_inc;
    logic [ROT_W-1:0]   rot_cnt, rot_nxt, rot_inc;
    logic [1:0]         phase_nxt, code_nxt, exp_phase;
    logic [3:0]         bit_nxt, rise, exp_rise;
    logic               stb_nxt, word_nxt, multi_hi;

    // Bit 0 is W so a line index equals its phase number
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            sync1      <= 4'd0;
            sync2      <= 4'd0;
            sync3      <= 4'd0;
            stall_cnt  <= '0;
            rot_cnt    <= '0;
            phase      <= 2'd0;
            phase_stb  <= 1'b0;
            bit_time   <= 4'd0;
            word_stb   <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            state      <= state_nxt;
            sync1      <= {z, y, x, w};
            sync2      <= sync1;
            sync3      <= sync2;
            stall_cnt  <= stall_nxt;
            rot_cnt    <= rot_nxt;
            phase      <= phase_nxt;
            phase_stb  <= stb_nxt;
            bit_time   <= bit_nxt;
            word_stb   <= word_nxt;
            locked     <= (state_nxt == LOCKED);
            fault      <= (state_nxt == FAULT);
            fault_code <= code_nxt;
        end
    end

    assign multi_hi  = (sync2 & (sync2 - 4'd1)) != 4'd0;
    assign rise      = sync2 & ~sync3;
    assign exp_phase = phase + 2'd1;
    assign exp_rise  = 4'b0001 << exp_phase;
    assign stall_inc = stall_cnt + STALL_W'(1);
    assign rot_inc   = rot_cnt + ROT_W'(1);

    // Next-state: overlap beats order/stall; the fault code is only written on entry to FAULT
    always_comb begin
        state_nxt = state;
        stall_nxt = stall_cnt;
        rot_nxt   = rot_cnt;
        phase_nxt = phase;
        bit_nxt   = bit_time;
        code_nxt  = fault_code;
        stb_nxt   = 1'b0;
        word_nxt  = 1'b0;
        case (state)
            HUNT: begin
                stall_nxt = '0;
                if (multi_hi) begin
                    state_nxt = FAULT;
                    code_nxt  = CODE_OVERLAP;
                end else if (rise[0]) begin
                    state_nxt = SYNC;
                    phase_nxt = 2'd0;
                    stb_nxt   = 1'b1;
                    rot_nxt   = '0;
                end
            end
            SYNC, LOCKED: begin
                if (multi_hi) begin
                    state_nxt = FAULT;
                    code_nxt  = CODE_OVERLAP;
                end else if (rise == exp_rise) begin
                    phase_nxt = exp_phase;
                    stb_nxt   = 1'b1;
                    stall_nxt = '0;
                    if (exp_phase == 2'd0) begin
                        if (state == SYNC) begin
                            rot_nxt = rot_inc;
                            if (rot_inc == ROT_W'(LOCK_CYCLES)) begin
                                state_nxt = LOCKED;
                                bit_nxt   = 4'd0;
                            end
                        end else if (bit_time == 4'(BIT_TIMES - 1)) begin
                            bit_nxt  = 4'd0;
                            word_nxt = 1'b1;
                        end else begin
                            bit_nxt = bit_time + 4'd1;
                        end
                    end
                end else if (rise != 4'd0) begin
                    state_nxt = FAULT;
                    code_nxt  = CODE_ORDER;
                end else begin
                    stall_nxt = stall_inc;
                    if (stall_inc == STALL_W'(STALL_MAX)) begin
                        state_nxt = FAULT;
                        code_nxt  = CODE_STALL;
                    end
                end
            end
            FAULT: begin
                stall_nxt = '0;
                if (fault_clr) begin
                    state_nxt = HUNT;
                    code_nxt  = CODE_NONE;
                    bit_nxt   = 4'd0;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

endmodule

// File: tb/tb_a1a3_clock_phase_monitor.sv
// Directed bench for a1a3_clock_phase_monitor: lock, word timing, fault codes, clear and reset.
`timescale 1ns/1ps
module tb_a1a3_clock_phase_monitor;

    logic       clk = 1'b0;
    logic       rst, w, x, y, z, fault_clr;
    logic [1:0] phase, fault_code;
    logic       phase_stb, word_stb, locked, fault;
    logic [3:0] bit_time;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int word_cnt = 0;
    int s0, w0;

    a1a3_clock_phase_monitor dut (
        .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z), .fault_clr(fault_clr),
        .phase(phase), .phase_stb(phase_stb), .bit_time(bit_time), .word_stb(word_stb),
        .locked(locked), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Strobe tallies, sampled mid-cycle
    always @(negedge clk) begin
        if (phase_stb) stb_cnt++;
        if (word_stb)  word_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int idx, input logic v);
        case (idx)
            0: w = v;
            1: x = v;
            2: y = v;
            default: z = v;
        endcase
    endtask

    task automatic pulse(input int idx);
        set_line(idx, 1'b1);
        wait_neg(8);
        set_line(idx, 1'b0);
        wait_neg(2);
    endtask

    task automatic rot(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(1); pulse(2); pulse(3); pulse(0);
        end
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        wait_neg(1);
        fault_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; w = 1'b0; x = 1'b0; y = 1'b0; z = 1'b0; fault_clr = 1'b0;
        wait_neg(2);
        check("rst_phase", phase, 0);
        check("rst_stb", phase_stb, 0);
        check("rst_bit", bit_time, 0);
        check("rst_word", word_stb, 0);
        check("rst_locked", locked, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        rst = 1'b0;
        wait_neg(2);

        // Clean rotation: lock on 5th W edge, then a full word
        s0 = stb_cnt; w0 = word_cnt;
        pulse(0);
        check("s1_hunt_stb", stb_cnt - s0, 1);
        check("s1_hunt_phase", phase, 0);
        check("s1_hunt_locked", locked, 0);
        rot(3);
        check("s1_not_locked_r3", locked, 0);
        check("s1_phase_r3", phase, 0);
        rot(1);
        check("s1_locked_r4", locked, 1);
        check("s1_bit_lock", bit_time, 0);
        rot(13);
        check("s1_bit13", bit_time, 13);
        check("s1_no_word", word_cnt - w0, 0);
        rot(1);
        check("s1_bit_wrap", bit_time, 0);
        check("s1_one_word", word_cnt - w0, 1);
        check("s1_stb_total", stb_cnt - s0, 73);
        check("s1_fault", fault, 0);

        // Overlap while locked
        rot(3);
        check("s2_bit3", bit_time, 3);
        s0 = stb_cnt;
        x = 1'b1; y = 1'b1;
        wait_neg(2);
        check("s2_fault_early", fault, 0);
        wait_neg(1);
        check("s2_fault", fault, 1);
        check("s2_code", fault_code, 1);
        check("s2_unlocked", locked, 0);
        wait_neg(5);
        x = 1'b0; y = 1'b0;
        wait_neg(4);
        check("s2_bit_frozen", bit_time, 3);
        check("s2_no_stb", stb_cnt - s0, 0);
        clear_fault();
        check("s2_clr_fault", fault, 0);
        check("s2_clr_code", fault_code, 0);
        check("s2_clr_bit", bit_time, 0);
        check("s2_clr_locked", locked, 0);

        // Order fault in SYNC, later overlap keeps code
        s0 = stb_cnt;
        pulse(0);
        check("s3_w_stb", stb_cnt - s0, 1);
        pulse(2);
        check("s3_fault", fault, 1);
        check("s3_code", fault_code, 2);
        check("s3_stb_count", stb_cnt - s0, 1);
        x = 1'b1; y = 1'b1;
        wait_neg(5);
        check("s3_code_kept", fault_code, 2);
        x = 1'b0; y = 1'b0;
        wait_neg(4);
        clear_fault();
        check("s3_clr", fault, 0);

        // Stall while locked: fault exactly 64 cycles after the last accepted edge
        pulse(0);
        rot(3);
        pulse(1); pulse(2); pulse(3);
        w = 1'b1;
        wait_neg(3);
        check("s4_locked", locked, 1);
        wait_neg(5);
        w = 1'b0;
        wait_neg(58);
        check("s4_no_fault_63", fault, 0);
        wait_neg(1);
        check("s4_fault_64", fault, 1);
        check("s4_code", fault_code, 3);
        check("s4_unlocked", locked, 0);
        clear_fault();
        check("s4_clr", fault, 0);

        // Stream starting at Z
        s0 = stb_cnt;
        pulse(3);
        check("s5_z_no_stb", stb_cnt - s0, 0);
        check("s5_z_fault", fault, 0);
        pulse(0);
        check("s5_w_stb", stb_cnt - s0, 1);
        rot(3);
        check("s5_not_locked", locked, 0);
        rot(1);
        check("s5_locked", locked, 1);
        check("s5_bit", bit_time, 0);

        // Asynchronous reset mid-word
        rot(7);
        check("s6_bit7", bit_time, 7);
        x = 1'b1;
        wait_neg(1);
        #2 rst = 1'b1;
        #1;
        check("s6_rst_phase", phase, 0);
        check("s6_rst_stb", phase_stb, 0);
        check("s6_rst_bit", bit_time, 0);
        check("s6_rst_word", word_stb, 0);
        check("s6_rst_locked", locked, 0);
        check("s6_rst_fault", fault, 0);
        check("s6_rst_code", fault_code, 0);
        x = 1'b0;
        wait_neg(2);
        rst = 1'b0;
        wait_neg(2);
        pulse(0);
        rot(3);
        check("s6_not_locked", locked, 0);
        rot(1);
        check("s6_relocked", locked, 1);
        check("s6_bit", bit_time, 0);
        check("s6_fault", fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
